// File: rtl/amiq_demux1_n.sv
`default_nettype none
// ============================================================================
// Module      : amiq_demux1_n
// Description : Registered 1-to-N demultiplexer with valid/ready handshake.
//               One input stream is steered to one of N_OUT output channels
//               chosen by sel. Each channel has a one-entry holding register.
//               Words addressed to a channel index >= N_OUT are accepted,
//               dropped, and flagged with a one-cycle drop_err pulse.
//               Optional per-channel transfer counters are enabled by
//               defining AMIQ_DEMUX_STATS_EN (adds ports cnt and cnt_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module amiq_demux1_n #(
  parameter  int WIDTH = 1,
  parameter  int N_OUT = 2,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
`ifdef AMIQ_DEMUX_STATS_EN
  output logic [N_OUT*CNT_W-1:0] cnt,
  input  logic                   cnt_clr,
`endif
  output logic                   drop_err
);

  // Per-channel decode and handshake terms
  logic [N_OUT-1:0] w_hit;    // sel addresses channel i (never set for out-of-range sel)
  logic [N_OUT-1:0] w_load;   // channel i captures in_data at the next edge
  logic [N_OUT-1:0] w_xfer;   // channel i hands its word to the consumer at the next edge
  logic             w_acc;    // input word accepted this cycle

  logic [N_OUT-1:0] r_valid;
  logic [WIDTH-1:0] r_data [N_OUT];
  logic             r_drop;

  // Elaboration-time sanity check of the configuration
  if (N_OUT < 2 || WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("amiq_demux1_n: requires N_OUT >= 2, WIDTH >= 1, CNT_W >= 1");
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_chan
    assign w_hit[i]                   = (sel == SEL_W'(i));
    assign w_load[i]                  = w_acc & w_hit[i];
    assign w_xfer[i]                  = r_valid[i] & out_ready[i];
    assign out_data[i*WIDTH +: WIDTH] = r_data[i];
  end

  // Only the addressed channel can stall the input; an out-of-range sel
  // matches no channel, so the word is always accepted (and dropped).
  assign in_ready  = ~|(w_hit & r_valid & ~out_ready);
  assign w_acc     = in_valid & in_ready;
  assign out_valid = r_valid;
  assign drop_err  = r_drop;

  // Holding registers: load wins over drain so a channel can refill in the
  // same cycle it is emptied; data is left untouched when a channel drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= in_data;
        end else if (w_xfer[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // One-cycle pulse for an accepted word that addressed no channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_acc & ~|w_hit;
    end
  end

`ifdef AMIQ_DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt [N_OUT];

  // Per-channel transfer counters; clear takes priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < N_OUT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_xfer[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
    assign cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`else
  // Statistics disabled: no counter state and no cnt/cnt_clr ports.
`endif

endmodule
`default_nettype wire
